block_assembly_fifo: RTL and testbench
======================================

Name: block_assembly_fifo

Overview:
- Parametrised successor to the UART-to-AES transmit buffer.
- Packs a serial byte stream from the UART receiver into fixed-size blocks, BLOCK_BYTES wide; default 16 bytes = 128-bit AES block.
- Stores up to DEPTH complete blocks in a circular FIFO for the AES core to read.
- New over the previous generation:
  - configurable block size and depth;
  - flush with padding of partial blocks;
  - fill level, full and partial-byte status;
  - defined behaviour for simultaneous commit and read.

Parameters:
BYTE_W  8  width of one input word from the receiver
BLOCK_BYTES  16  input words per block; block width BW = BYTE_W*BLOCK_BYTES
DEPTH  4  number of complete blocks stored; power of two, >= 2
PAD_BYTE  8'h00  value used to fill unused byte lanes on flush

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
din  in  BYTE_W  input word, qualified by ready
ready  in  1  one-cycle strobe: din valid (receiver done flag)
flush  in  1  one-cycle strobe: pad and commit the partial block
read_en  in  1  pop the head block
dout  out  BW  block read out, registered
dout_valid  out  1  one-cycle pulse: dout updated by an accepted read
empty  out  1  no complete block stored
full  out  1  DEPTH blocks stored
level  out  clog2(DEPTH+1)  number of complete blocks stored
partial  out  clog2(BLOCK_BYTES)  bytes held in the assembly register
overflow  out  1  sticky: a completed block was dropped

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (sampled high at the clk edge):
  - clears the write and read pointers, level, byte counter and assembly register;
  - dout=0, dout_valid=0, overflow=0;
  - the result is empty=1, full=0, level=0, partial=0;
  - any partial block is discarded.
  - Reset has priority over every other input.
- Byte order:
  - the first byte of a block lands in the MSB lane dout[BW-1 -: BYTE_W];
  - the last byte lands in dout[BYTE_W-1:0].
- Assembly, on ready=1:
  - din is written to lane index partial;
  - partial increments.
  - When the byte fills lane BLOCK_BYTES-1, the block is complete: a commit is requested and partial wraps to 0 in the same cycle.
- Flush, on flush=1 with partial>0 after this cycle's byte (if any):
  - remaining lanes are set to PAD_BYTE;
  - a commit is requested;
  - partial returns to 0.
- Flush no-op cases:
  - flush with partial=0 and no byte is a no-op;
  - flush in the same cycle as a block-completing byte adds no extra block.
- Commit:
  - if full=0, or a read is accepted in the same cycle, the block is written at wr_ptr, wr_ptr increments mod DEPTH, and level increments.
  - Otherwise the block is dropped, overflow is set to 1, and level is unchanged.
  - The assembly register is cleared either way.
- Read, on read_en=1 with empty=0:
  - dout <= mem[rd_ptr]; dout_valid=1 on the following cycle;
  - rd_ptr increments mod DEPTH; level decrements.
- read_en while empty:
  - ignored; dout holds its value, dout_valid=0;
  - not an error.
- Commit and read in the same cycle:
  - level unchanged;
  - both pointers advance;
  - valid at full: no overflow.
  - At empty, the read is ignored; the new block becomes readable on the next cycle (no fall-through).
- Status flags:
  - empty = (level==0); full = (level==DEPTH); both are derived from registered level.
  - overflow stays 1 until reset.
- Latency:
  - the last byte at edge N gives empty=0 after edge N;
  - read_en at edge M gives dout/dout_valid after edge M.
- dout holds its last value between reads.

Test Plan:
1. Reset, then 16 ready strobes with din=8'h00..8'h0F -> level=1, empty=0; read_en -> next cycle dout=128'h000102030405060708090A0B0C0D0E0F, dout_valid=1 for one cycle, empty=1.
2. 5 bytes 8'hA1..8'hA5, then flush -> partial=0, level=1; read gives dout=128'hA1A2A3A4A5 followed by 11 zero bytes. A second flush with partial=0 leaves level=1.
3. Write 4 full blocks (DEPTH=4) -> full=1. A 5th block -> overflow=1, level=4, and the 4 reads return blocks 1-4 in order.
4. With full=1, complete a block in the same cycle as read_en -> overflow stays 0, level stays 4, and all 4 later reads are ordered correctly, exercising pointer wrap-around.
5. Assert reset mid-block (partial=7, level=2) -> all outputs at reset values next cycle; the next 16 bytes form a clean block starting at the MSB lane.
6. read_en with empty=1 -> dout unchanged, dout_valid=0. Byte plus flush in the same cycle at partial=3 -> the block holds 4 data bytes then 12 PAD_BYTE.

Source files
------------

// File: rtl/block_assembly_fifo_if.sv
// rtl/block_assembly_fifo_if.sv - byte-in / block-out bus of the block assembly FIFO
interface block_assembly_fifo_if #(
  parameter int BYTE_W      = 8,
  parameter int BLOCK_BYTES = 16,
  parameter int DEPTH       = 4
);
  localparam int BW = BYTE_W * BLOCK_BYTES;

  logic [BYTE_W-1:0]              din;
  logic                           ready;
  logic                           flush;
  logic                           read_en;
  logic [BW-1:0]                  dout;
  logic                           dout_valid;
  logic                           empty;
  logic                           full;
  logic [$clog2(DEPTH+1)-1:0]     level;
  logic [$clog2(BLOCK_BYTES)-1:0] partial;
  logic                           overflow;

  modport master (
    output din, ready, flush, read_en,
    input  dout, dout_valid, empty, full, level, partial, overflow
  );

  modport slave (
    input  din, ready, flush, read_en,
    output dout, dout_valid, empty, full, level, partial, overflow
  );
endinterface

// File: rtl/block_assembly_fifo.sv
// rtl/block_assembly_fifo.sv - packs a byte stream into blocks and queues them for the cipher core
module block_assembly_fifo #(
  parameter int                BYTE_W      = 8,
  parameter int                BLOCK_BYTES = 16,
  parameter int                DEPTH       = 4,
  parameter logic [BYTE_W-1:0] PAD_BYTE    = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  block_assembly_fifo_if.slave bus
);
  localparam int BW = BYTE_W * BLOCK_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(BLOCK_BYTES);

  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] asm_q;
  logic [PW-1:0] cnt_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [BW-1:0] dout_q;
  logic          dout_valid_q;
  logic          overflow_q;

  logic [BW-1:0] asm_next;
  logic [BW-1:0] commit_data;
  logic [PW-1:0] cnt_next;
  logic          block_done;
  logic          do_flush;
  logic          commit;
  logic          full;
  logic          rd_fire;
  logic          wr_fire;

  assign full = (level_q == LW'(DEPTH));

  // Place this cycle's byte, detect completion, pad on flush and resolve commit/read arbitration
  always_comb begin
    asm_next    = asm_q;
    cnt_next    = cnt_q;
    block_done  = 1'b0;
    if (bus.ready) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (cnt_q == PW'(i)) asm_next[BW-1-i*BYTE_W -: BYTE_W] = bus.din;
      end
      if (cnt_q == PW'(BLOCK_BYTES - 1)) begin
        block_done = 1'b1;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_q + PW'(1);
      end
    end
    // A flush alongside a completing byte has nothing left to pad, so it adds no block
    do_flush    = bus.flush && !block_done && (cnt_next != '0);
    commit_data = asm_next;
    if (do_flush) begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
        if (i >= int'(cnt_next)) commit_data[BW-1-i*BYTE_W -: BYTE_W] = PAD_BYTE;
      end
    end
    commit  = block_done || do_flush;
    rd_fire = bus.read_en && (level_q != '0);
    // A read in the same cycle frees the head slot, so a commit at full still fits
    wr_fire = commit && (!full || rd_fire);
  end

  // Block storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) mem[wr_ptr] <= commit_data;
  end

  // Assembly register, pointers, level, read data and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q        <= '0;
      cnt_q        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (commit) begin
        asm_q <= '0;
        cnt_q <= '0;
      end else begin
        asm_q <= asm_next;
        cnt_q <= cnt_next;
      end
      if (commit && !wr_fire) overflow_q <= 1'b1;
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      dout_valid_q <= rd_fire;
      if (rd_fire) begin
        dout_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.empty      = (level_q == '0);
  assign bus.full       = full;
  assign bus.level      = level_q;
  assign bus.partial    = cnt_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_block_assembly_fifo.sv
// tb/tb_block_assembly_fifo.sv - scoreboard bench for block_assembly_fifo
module tb_block_assembly_fifo;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  block_assembly_fifo_if #(.BYTE_W(8), .BLOCK_BYTES(16), .DEPTH(4)) bus ();

  block_assembly_fifo #(
    .BYTE_W(8), .BLOCK_BYTES(16), .DEPTH(4), .PAD_BYTE(8'h00)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0] exp_q[$];
  logic [127:0] m_asm;
  int           m_part;
  int           m_level;
  bit           m_ovf;
  bit           last_rd;
  logic [127:0] last_exp;

  // Drives one cycle of stimulus and updates the reference model / scoreboard
  task automatic cycle(input logic rdy, input logic [7:0] d, input logic fl, input logic rd);
    bit commit;
    commit      = 1'b0;
    bus.ready   = rdy;
    bus.din     = d;
    bus.flush   = fl;
    bus.read_en = rd;
    last_rd     = rd && (m_level > 0);
    if (last_rd) last_exp = exp_q.pop_front();
    if (rdy) begin
      m_asm[127-m_part*8 -: 8] = d;
      m_part++;
      if (m_part == 16) begin
        commit = 1'b1;
        m_part = 0;
      end
    end
    if (fl && !commit && m_part > 0) begin
      for (int i = m_part; i < 16; i++) m_asm[127-i*8 -: 8] = 8'h00;
      commit = 1'b1;
      m_part = 0;
    end
    if (commit) begin
      if (m_level < 4 || last_rd) begin
        exp_q.push_back(m_asm);
        m_level++;
      end else begin
        m_ovf = 1'b1;
      end
      m_asm = '0;
    end
    if (last_rd) m_level--;
    @(posedge clk);
    @(negedge clk);
    bus.ready   = 1'b0;
    bus.din     = 8'h00;
    bus.flush   = 1'b0;
    bus.read_en = 1'b0;
  endtask

  task automatic write_block(input logic [7:0] base);
    for (int i = 0; i < 16; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    m_asm   = '0;
    m_part  = 0;
    m_level = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.level !== 3'd0 || bus.partial !== 4'd0) begin
      errors++;
      $display("FAIL reset_flags: empty=%b full=%b level=%0d partial=%0d, expected 1 0 0 0",
               bus.empty, bus.full, bus.level, bus.partial);
    end
    checks++;
    if (bus.dout !== 128'h0 || bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: dout=%h valid=%b ovf=%b, expected 0 0 0",
               bus.dout, bus.dout_valid, bus.overflow);
    end
  endtask

  task automatic test_full_block();
    write_block(8'h00);
    checks++;
    if (bus.level !== 3'd1 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL block_level: level=%0d empty=%b, expected 1 0", bus.level, bus.empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 128'h000102030405060708090A0B0C0D0E0F ||
        bus.dout !== last_exp) begin
      errors++;
      $display("FAIL block_read: dout=%h valid=%b, expected 000102030405060708090a0b0c0d0e0f valid=1",
               bus.dout, bus.dout_valid);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL block_after: valid=%b empty=%b, expected 0 1", bus.dout_valid, bus.empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (bus.partial !== 4'd5) begin
      errors++;
      $display("FAIL flush_partial5: partial=%0d, expected 5", bus.partial);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.partial !== 4'd0 || bus.level !== 3'd1) begin
      errors++;
      $display("FAIL flush_commit: partial=%0d level=%0d, expected 0 1", bus.partial, bus.level);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (bus.level !== 3'd1) begin
      errors++;
      $display("FAIL flush_noop: level=%0d, expected 1", bus.level);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== {40'hA1A2A3A4A5, 88'h0} || bus.dout !== last_exp) begin
      errors++;
      $display("FAIL flush_read: dout=%h valid=%b, expected %h valid=1",
               bus.dout, bus.dout_valid, {40'hA1A2A3A4A5, 88'h0});
    end
  endtask

  task automatic test_overflow();
    write_block(8'h10);
    write_block(8'h20);
    write_block(8'h30);
    write_block(8'h40);
    checks++;
    if (bus.full !== 1'b1 || bus.level !== 3'd4 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full=%b level=%0d ovf=%b, expected 1 4 0", bus.full, bus.level, bus.overflow);
    end
    write_block(8'h50);
    checks++;
    if (bus.overflow !== 1'b1 || bus.level !== 3'd4 || m_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%b level=%0d, expected 1 4", bus.overflow, bus.level);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== last_exp || bus.dout[127:120] !== 8'h10 + 8'(k*16)) begin
        errors++;
        $display("FAIL ovf_read%0d: dout=%h valid=%b, expected %h valid=1", k, bus.dout, bus.dout_valid, last_exp);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: empty=%b ovf=%b, expected 1 1", bus.empty, bus.overflow);
    end
  endtask

  task automatic test_simul_full();
    do_reset();
    write_block(8'h40);
    write_block(8'h50);
    write_block(8'h60);
    write_block(8'h70);
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h8F, 1'b0, 1'b1);
    checks++;
    if (bus.overflow !== 1'b0 || bus.level !== 3'd4 || bus.dout_valid !== 1'b1 || bus.dout !== last_exp) begin
      errors++;
      $display("FAIL simul_commit: ovf=%b level=%0d valid=%b dout=%h, expected 0 4 1 %h",
               bus.overflow, bus.level, bus.dout_valid, bus.dout, last_exp);
    end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      checks++;
      if (bus.dout_valid !== 1'b1 || bus.dout !== last_exp || bus.dout[7:0] !== 8'h5F + 8'(k*16)) begin
        errors++;
        $display("FAIL simul_read%0d: dout=%h valid=%b, expected %h valid=1", k, bus.dout, bus.dout_valid, last_exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    write_block(8'h90);
    write_block(8'hA0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (bus.partial !== 4'd7 || bus.level !== 3'd2) begin
      errors++;
      $display("FAIL mid_state: partial=%0d level=%0d, expected 7 2", bus.partial, bus.level);
    end
    do_reset();
    checks++;
    if (bus.partial !== 4'd0 || bus.level !== 3'd0 || bus.empty !== 1'b1 || bus.dout !== 128'h0 ||
        bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: partial=%0d level=%0d empty=%b dout=%h, expected 0 0 1 0",
               bus.partial, bus.level, bus.empty, bus.dout);
    end
    write_block(8'hB0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF || bus.dout !== last_exp) begin
      errors++;
      $display("FAIL mid_clean: dout=%h valid=%b, expected b0b1b2b3b4b5b6b7b8b9babbbcbdbebf", bus.dout, bus.dout_valid);
    end
  endtask

  task automatic test_empty_read();
    logic [127:0] prev;
    prev = last_exp;
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== prev) begin
      errors++;
      $display("FAIL empty_read: dout=%h valid=%b, expected %h valid=0", bus.dout, bus.dout_valid, prev);
    end
    for (int i = 0; i < 15; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h2F, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.level !== 3'd1 || bus.empty !== 1'b0 || bus.dout !== prev) begin
      errors++;
      $display("FAIL empty_commit_read: valid=%b level=%0d empty=%b, expected 0 1 0",
               bus.dout_valid, bus.level, bus.empty);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== last_exp || bus.dout[127:120] !== 8'h20) begin
      errors++;
      $display("FAIL empty_next_read: dout=%h valid=%b, expected %h valid=1", bus.dout, bus.dout_valid, last_exp);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC1 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hC4, 1'b1, 1'b0);
    checks++;
    if (bus.partial !== 4'd0 || bus.level !== 3'd1) begin
      errors++;
      $display("FAIL pad_commit: partial=%0d level=%0d, expected 0 1", bus.partial, bus.level);
    end
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== {32'hC1C2C3C4, 96'h0} || bus.dout !== last_exp) begin
      errors++;
      $display("FAIL pad_read: dout=%h valid=%b, expected %h valid=1", bus.dout, bus.dout_valid, {32'hC1C2C3C4, 96'h0});
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.din     = 8'h00;
    bus.ready   = 1'b0;
    bus.flush   = 1'b0;
    bus.read_en = 1'b0;
    last_exp    = '0;
    @(negedge clk);
    test_reset();
    test_full_block();
    test_flush();
    test_overflow();
    test_simul_full();
    test_reset_mid();
    test_empty_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
